// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare of the shift window against the programmed pattern; only the low len bits matter.
module seq_match_cmp
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        hit = ((window ^ pattern) & mask) == '0;
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control, match pulse and saturating counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               busy
);

    state_t             state;
    logic [MAX_LEN-2:0] history;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               cmp_hit;
    logic               fill_ok;
    logic               cfg_legal;
    logic               accept;
    logic               hit;

    // Window includes the bit arriving this cycle, so a hit is known at the accepting edge.
    assign window    = {history, in};
    assign fill_ok   = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len};
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign accept    = (state == RUN) && in_valid && !cfg_we;
    assign hit       = accept && fill_ok && cmp_hit;

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window  (window),
        .pattern (pattern),
        .len     (len),
        .hit     (cmp_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= UNCFG;
            history     <= '0;
            fill        <= '0;
            pattern     <= '0;
            len         <= '0;
            overlap     <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            match <= hit;

            if (cnt_clr) begin
                match_count <= '0;
            end else if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end

            if (cfg_we) begin
                if (cfg_legal) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
                    history <= '0;
                    fill    <= '0;
                    cfg_err <= 1'b0;
                end else begin
                    state   <= UNCFG;
                    busy    <= 1'b0;
                    cfg_err <= 1'b1;
                end
            end else if (accept) begin
                if (hit && !overlap) begin
                    history <= '0;
                    fill    <= '0;
                end else begin
                    history <= window[MAX_LEN-2:0];
                    if (fill != LEN_W'(MAX_LEN)) begin
                        fill <= fill + LEN_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed table-driven bench for seq_detector_prog (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 2;

    logic               clk;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               busy;

    int checks = 0;
    int errors = 0;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       cfg;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       v;
        logic       b;
        logic       clr;
        logic       m;
        logic [1:0] cnt;
        logic       bsy;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(logic cfg, logic [7:0] pat, logic [3:0] len, logic ovl,
                               logic v, logic b, logic clr,
                               logic m, logic [1:0] cnt, logic bsy, logic err);
        vec_t t;
        t.cfg = cfg; t.pat = pat; t.len = len; t.ovl = ovl;
        t.v = v; t.b = b; t.clr = clr;
        t.m = m; t.cnt = cnt; t.bsy = bsy; t.err = err;
        return t;
    endfunction

    function automatic vec_t cf(logic [7:0] pat, logic [3:0] len, logic ovl, logic [1:0] cnt);
        return r(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 1'b0, cnt, 1'b1, 1'b0);
    endfunction

    function automatic vec_t bt(logic b, logic m, logic [1:0] cnt);
        return r(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, 1'b0, m, cnt, 1'b1, 1'b0);
    endfunction

    function automatic vec_t gp(logic [1:0] cnt);
        return r(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt, 1'b1, 1'b0);
    endfunction

    function automatic vec_t cl();
        return r(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        cfg_we      = t.cfg;
        cfg_pattern = t.pat;
        cfg_len     = t.len;
        cfg_overlap = t.ovl;
        in_valid    = t.v;
        in          = t.b;
        cnt_clr     = t.clr;
        @(posedge clk);
        #1;
        chk("match",   idx, {7'b0, match},   {7'b0, t.m});
        chk("count",   idx, {6'b0, match_count}, {6'b0, t.cnt});
        chk("busy",    idx, {7'b0, busy},    {7'b0, t.bsy});
        chk("cfg_err", idx, {7'b0, cfg_err}, {7'b0, t.err});
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; in_valid = 1'b0; in = 1'b0; cnt_clr = 1'b0;

        // 1010 overlapping: hits on bits 4 and 6
        tbl.push_back(cf(8'h0A, 4'd4, 1'b1, 2'd0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(bt(0, 0, 0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(bt(0, 1, 1));
        tbl.push_back(bt(1, 0, 1)); tbl.push_back(bt(0, 1, 2));
        tbl.push_back(cl());
        // 1010 non-overlapping: hits on bits 4 and 8
        tbl.push_back(cf(8'h0A, 4'd4, 1'b0, 2'd0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(bt(0, 0, 0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(bt(0, 1, 1));
        tbl.push_back(bt(1, 0, 1)); tbl.push_back(bt(0, 0, 1));
        tbl.push_back(bt(1, 0, 1)); tbl.push_back(bt(0, 1, 2));
        tbl.push_back(cl());
        // 111 with gaps, then back-to-back overlapping
        tbl.push_back(cf(8'h07, 4'd3, 1'b1, 2'd0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(gp(0)); tbl.push_back(gp(0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(gp(0)); tbl.push_back(gp(0));
        tbl.push_back(bt(1, 1, 1)); tbl.push_back(gp(1));
        tbl.push_back(cl());
        tbl.push_back(cf(8'h07, 4'd3, 1'b1, 2'd0));
        tbl.push_back(bt(1, 0, 0)); tbl.push_back(bt(1, 0, 0));
        tbl.push_back(bt(1, 1, 1)); tbl.push_back(bt(1, 1, 2));
        // counter saturation at 3, then clear beating a same-cycle hit
        tbl.push_back(cl());
        tbl.push_back(bt(1, 1, 1)); tbl.push_back(bt(1, 1, 2)); tbl.push_back(bt(1, 1, 3));
        tbl.push_back(bt(1, 1, 3)); tbl.push_back(bt(1, 1, 3));
        tbl.push_back(r(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 2'd0, 1, 0));
        tbl.push_back(bt(1, 1, 1));
        // illegal lengths drop to UNCFG; input ignored there
        tbl.push_back(r(1, 8'h07, 4'd0, 1, 0, 0, 0, 0, 2'd1, 0, 1));
        tbl.push_back(r(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
        tbl.push_back(r(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
        tbl.push_back(r(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd1, 0, 1));
        tbl.push_back(r(1, 8'h07, 4'd9, 1, 0, 0, 0, 0, 2'd1, 0, 1));
        // 8-bit pattern A5
        tbl.push_back(cf(8'hA5, 4'd8, 1'b1, 2'd1));
        tbl.push_back(bt(1, 0, 1)); tbl.push_back(bt(0, 0, 1)); tbl.push_back(bt(1, 0, 1));
        tbl.push_back(bt(0, 0, 1)); tbl.push_back(bt(0, 0, 1)); tbl.push_back(bt(1, 0, 1));
        tbl.push_back(bt(0, 0, 1)); tbl.push_back(bt(1, 1, 2));
        // reconfig after a 4-bit prefix must discard it
        tbl.push_back(bt(1, 0, 2)); tbl.push_back(bt(0, 0, 2));
        tbl.push_back(bt(1, 0, 2)); tbl.push_back(bt(0, 0, 2));
        tbl.push_back(cf(8'hA5, 4'd8, 1'b1, 2'd2));
        tbl.push_back(bt(0, 0, 2)); tbl.push_back(bt(1, 0, 2));
        tbl.push_back(bt(0, 0, 2)); tbl.push_back(bt(1, 0, 2));
        // len=1, and cfg_we dropping a same-cycle valid bit
        tbl.push_back(cl());
        tbl.push_back(cf(8'h01, 4'd1, 1'b1, 2'd0));
        tbl.push_back(bt(1, 1, 1)); tbl.push_back(bt(0, 0, 1)); tbl.push_back(bt(1, 1, 2));
        tbl.push_back(r(1, 8'h01, 4'd1, 1, 1, 1, 0, 0, 2'd2, 1, 0));
        tbl.push_back(bt(1, 1, 3));

        #12;
        chk("rst_match",   -1, {7'b0, match},   8'h00);
        chk("rst_count",   -1, {6'b0, match_count}, 8'h00);
        chk("rst_busy",    -1, {7'b0, busy},    8'h00);
        chk("rst_cfg_err", -1, {7'b0, cfg_err}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // async reset between bits 3 and 4 of 1010
        apply(cf(8'h0A, 4'd4, 1'b1, 2'd3), 1000);
        apply(bt(1, 0, 3), 1001);
        apply(bt(0, 0, 3), 1002);
        apply(bt(1, 0, 3), 1003);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_match",   1004, {7'b0, match},   8'h00);
        chk("async_count",   1004, {6'b0, match_count}, 8'h00);
        chk("async_busy",    1004, {7'b0, busy},    8'h00);
        chk("async_cfg_err", 1004, {7'b0, cfg_err}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply(r(0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 2'd0, 0, 0), 1005);
        apply(r(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 2'd0, 0, 0), 1006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
